branch_target_predictor: RTL

Dynamic branch predictor with a direct-mapped branch target buffer (BTB) and saturating-counter direction table, parametrised in depth, counter width and address width. It serves the fetch stage by predicting taken/not-taken and the target for the current PC in the same cycle. The execute stage trains it with resolved branch outcomes. It also keeps saturating statistics counters for resolved branches and mispredictions.

---
 rtl/branch_target_predictor.sv | 128 ++++++++++++
 1 files changed

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Combinational lookup for fetch; one-cycle update from execute; saturating statistics.
module branch_target_predictor #(
    parameter int unsigned ADDRESS_LEN  = 12,
    parameter int unsigned INDEX_BITS   = 4,
    parameter int unsigned COUNTER_BITS = 2,
    parameter int unsigned STAT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [ADDRESS_LEN-1:0] fetch_pc,
    output logic                   predict_hit,
    output logic                   predict_taken,
    output logic [ADDRESS_LEN-1:0] predict_target,
    input  logic                   update_valid,
    input  logic [ADDRESS_LEN-1:0] update_pc,
    input  logic                   update_taken,
    input  logic [ADDRESS_LEN-1:0] update_target,
    input  logic                   update_pred_taken,
    output logic [STAT_WIDTH-1:0]  resolved_count,
    output logic [STAT_WIDTH-1:0]  mispredict_count
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W   = ADDRESS_LEN - INDEX_BITS;
    localparam int unsigned WT_INT  = 1 << (COUNTER_BITS - 1);

    localparam logic [COUNTER_BITS-1:0] CTR_MAX = '1;
    localparam logic [COUNTER_BITS-1:0] CTR_WT  = COUNTER_BITS'(WT_INT);
    localparam logic [COUNTER_BITS-1:0] CTR_WNT = COUNTER_BITS'(WT_INT - 1);

    logic [ENTRIES-1:0]      valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q    [ENTRIES];
    logic [TAG_W-1:0]        tag_d    [ENTRIES];
    logic [ADDRESS_LEN-1:0]  target_q [ENTRIES];
    logic [ADDRESS_LEN-1:0]  target_d [ENTRIES];
    logic [COUNTER_BITS-1:0] ctr_q    [ENTRIES];
    logic [COUNTER_BITS-1:0] ctr_d    [ENTRIES];
    logic [STAT_WIDTH-1:0]   resolved_q, resolved_d;
    logic [STAT_WIDTH-1:0]   mispredict_q, mispredict_d;

    logic [INDEX_BITS-1:0]   fetch_idx;
    logic [TAG_W-1:0]        fetch_tag;
    logic                    fetch_hit;
    logic [INDEX_BITS-1:0]   upd_idx;
    logic [TAG_W-1:0]        upd_tag;
    logic                    upd_hit;

    assign fetch_idx = fetch_pc[INDEX_BITS-1:0];
    assign fetch_tag = fetch_pc[ADDRESS_LEN-1:INDEX_BITS];
    assign upd_idx   = update_pc[INDEX_BITS-1:0];
    assign upd_tag   = update_pc[ADDRESS_LEN-1:INDEX_BITS];

    assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Lookup reads registered state only, so a same-cycle update is never bypassed.
    always_comb begin
        predict_hit    = fetch_hit;
        predict_taken  = fetch_hit && ctr_q[fetch_idx][COUNTER_BITS-1];
        predict_target = fetch_hit ? target_q[fetch_idx] : '0;
    end

    assign resolved_count   = resolved_q;
    assign mispredict_count = mispredict_q;

    always_comb begin
        resolved_d   = resolved_q;
        mispredict_d = mispredict_q;
        if (update_valid) begin
            if (resolved_q != '1) begin
                resolved_d = resolved_q + STAT_WIDTH'(1);
            end
            if ((update_taken != update_pred_taken) && (mispredict_q != '1)) begin
                mispredict_d = mispredict_q + STAT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (clear) begin
            valid_d = '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_d[i] = CTR_WNT;
            end
        end else if (update_valid) begin
            if (upd_hit) begin
                if (update_taken) begin
                    target_d[upd_idx] = update_target;
                    if (ctr_q[upd_idx] != CTR_MAX) begin
                        ctr_d[upd_idx] = ctr_q[upd_idx] + COUNTER_BITS'(1);
                    end
                end else if (ctr_q[upd_idx] != '0) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - COUNTER_BITS'(1);
                end
            end else if (update_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = update_target;
                ctr_d[upd_idx]    = CTR_WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            resolved_q   <= '0;
            mispredict_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else begin
            valid_q      <= valid_d;
            resolved_q   <= resolved_d;
            mispredict_q <= mispredict_d;
            ctr_q        <= ctr_d;
            tag_q        <= tag_d;
            target_q     <= target_d;
        end
    end

endmodule
